// File: rtl/led_pkg.sv
// Shared definitions for the LED code scheduler: FSM encoding and the
// per-requester bit-mask helpers used to build ack and overrun pulses.
package led_pkg;

    localparam int MAX_REQ = 8;
    localparam int TIMER_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_e;

    // One-hot mask for a requester index; callers narrow it to NUM_REQ bits.
    function automatic logic [MAX_REQ-1:0] idx_mask(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Fixed priority: index 0 wins.
    function automatic logic [2:0] lowest_set(input logic [MAX_REQ-1:0] v);
        logic [2:0] sel;
        sel = 3'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (v[i]) sel = 3'(i);
        end
        return sel;
    endfunction

    function automatic logic [MAX_REQ-1:0] overrun_mask(input logic [MAX_REQ-1:0] req_v,
                                                        input logic [MAX_REQ-1:0] pend_v);
        return req_v & pend_v;
    endfunction

endpackage

// File: rtl/led_code_timer.sv
// 32-bit down-counter for the blink phases: load has priority over decrement,
// and the count parks at zero.
module led_code_timer
    import led_pkg::*;
(
    input  logic               clk,
    input  logic               n_reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_code_sched.sv
// Blinks requester i's code (i+1 blinks then a long gap) on a single LED,
// serving latched requests in fixed priority, one code at a time.
module led_code_sched
    import led_pkg::*;
#(
    parameter int          NUM_REQ  = 4,
    parameter logic [31:0] ON_CLKS  = 32'd1024,
    parameter logic [31:0] OFF_CLKS = 32'd1024,
    parameter logic [31:0] GAP_CLKS = 32'd4096
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic               led,
    output logic               busy,
    output logic [2:0]         grant,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] overrun,
    output led_state_e         state_dbg
);

    // Protocol: req is a level sampled every clock and latched into pending;
    // ack is a single-clock pulse on the granted bit when its gap ends.

    led_state_e           state, state_next;
    logic [NUM_REQ-1:0]   pending, clear_mask, ack_next;
    logic [3:0]           blinks_left, blinks_next;
    logic [2:0]           grant_next, start_idx;
    logic                 led_next, start;
    logic                 timer_load, timer_zero;
    logic [TIMER_W-1:0]   timer_val;

    assign start_idx = lowest_set(MAX_REQ'(pending));

    led_code_timer u_timer (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (state != ST_IDLE),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (n_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            ST_IDLE: if (enable && (pending != '0)) begin
                state_next = ST_ON;
                start      = 1'b1;
            end
            ST_ON:   if (timer_zero) state_next = (blinks_left == 4'd1) ? ST_GAP : ST_OFF;
            ST_OFF:  if (timer_zero) state_next = ST_ON;
            ST_GAP:  if (timer_zero) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        led_next    = led;
        blinks_next = blinks_left;
        grant_next  = grant;
        ack_next    = '0;
        clear_mask  = '0;
        timer_load  = 1'b0;
        timer_val   = '0;
        case (state)
            ST_IDLE: if (start) begin
                grant_next  = start_idx;
                clear_mask  = NUM_REQ'(idx_mask(start_idx));
                blinks_next = {1'b0, start_idx} + 4'd1;
                led_next    = 1'b1;
                timer_load  = 1'b1;
                timer_val   = ON_CLKS - 32'd1;
            end
            ST_ON: if (timer_zero) begin
                led_next    = 1'b0;
                blinks_next = blinks_left - 4'd1;
                timer_load  = 1'b1;
                timer_val   = (blinks_left == 4'd1) ? (GAP_CLKS - 32'd1) : (OFF_CLKS - 32'd1);
            end
            ST_OFF: if (timer_zero) begin
                led_next   = 1'b1;
                timer_load = 1'b1;
                timer_val  = ON_CLKS - 32'd1;
            end
            ST_GAP: if (timer_zero) begin
                ack_next = NUM_REQ'(idx_mask(grant));
            end
            default: ;
        endcase
    end

    // A req arriving on the start edge re-sets the bit being cleared.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            led         <= 1'b0;
            grant       <= 3'd0;
            blinks_left <= 4'd0;
            pending     <= '0;
            ack         <= '0;
            overrun     <= '0;
        end else begin
            led         <= led_next;
            grant       <= grant_next;
            blinks_left <= blinks_next;
            pending     <= (pending & ~clear_mask) | req;
            ack         <= ack_next;
            overrun     <= NUM_REQ'(overrun_mask(MAX_REQ'(req), MAX_REQ'(pending)));
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_led_code_sched.sv
// Bench for led_code_sched: per-cycle comparison against a schedule-queue
// model, plus directed cases with hand-computed totals.
module tb_led_code_sched;
  import led_pkg::*;

  localparam int          N   = 4;
  localparam logic [31:0] ON  = 32'd4;
  localparam logic [31:0] OFF = 32'd3;
  localparam logic [31:0] GAP = 32'd10;

  // ---------------- clock / reset ----------------
  bit clk;
  logic n_reset = 1'b1;
  logic enable = 1'b0;
  logic [N-1:0] req = '0;
  logic led, busy;
  logic [2:0] grant;
  logic [N-1:0] ack, overrun;
  led_state_e state_dbg;

  always #5 clk = ~clk;

  led_code_sched #(
    .NUM_REQ (N),
    .ON_CLKS (ON),
    .OFF_CLKS(OFF),
    .GAP_CLKS(GAP)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .enable   (enable),
    .req      (req),
    .led      (led),
    .busy     (busy),
    .grant    (grant),
    .ack      (ack),
    .overrun  (overrun),
    .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each code is expanded into a queue of per-cycle outputs when it starts:
  // (i+1) on-runs separated by off-runs, a gap run, then one idle cycle with ack.
  typedef struct packed { logic led; logic busy; logic ack; } ent_t;
  ent_t exp_q[$];
  logic [N-1:0] m_pend = '0, m_ack = '0, m_over = '0;
  logic m_led = 1'b0, m_busy = 1'b0;
  logic [2:0] m_grant = 3'd0;
  bit started;

  always @(posedge clk) begin : model
    logic [N-1:0] nxt;
    int sel;
    ent_t e;
    started = 1'b1;
    if (n_reset) begin
      exp_q.delete();
      m_pend = '0; m_ack = '0; m_over = '0;
      m_led = 1'b0; m_busy = 1'b0; m_grant = 3'd0;
    end else begin
      m_over = req & m_pend;
      nxt = m_pend | req;
      if (exp_q.size() == 0 && enable && m_pend != '0) begin
        sel = -1;
        for (int k = N - 1; k >= 0; k--) if (m_pend[k]) sel = k;
        m_grant = 3'(sel);
        nxt = (m_pend & ~(N'(1) << sel)) | req;
        for (int b = 0; b <= sel; b++) begin
          repeat (ON) exp_q.push_back('{led: 1'b1, busy: 1'b1, ack: 1'b0});
          if (b < sel) repeat (OFF) exp_q.push_back('{led: 1'b0, busy: 1'b1, ack: 1'b0});
          else         repeat (GAP) exp_q.push_back('{led: 1'b0, busy: 1'b1, ack: 1'b0});
        end
        exp_q.push_back('{led: 1'b0, busy: 1'b0, ack: 1'b1});
      end
      m_pend = nxt;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_led = e.led;
        m_busy = e.busy;
        m_ack = e.ack ? (N'(1) << m_grant) : '0;
      end else begin
        m_led = 1'b0; m_busy = 1'b0; m_ack = '0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("led", 32'(led), 32'(m_led));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant", 32'(grant), 32'(m_grant));
      chk("ack", 32'(ack), 32'(m_ack));
      chk("overrun", 32'(overrun), 32'(m_over));
      chk("state_idle", 32'(state_dbg == ST_IDLE), 32'(!m_busy));
    end
  end

  // ---------------- driver ----------------
  logic [N-1:0] rq_s [16];
  logic         en_s [16];
  logic         rs_s [16];

  task automatic clear_stim(input logic en_v);
    for (int i = 0; i < 16; i++) begin
      rq_s[i] = '0;
      en_s[i] = en_v;
      rs_s[i] = 1'b0;
    end
  endtask

  int busy_n, rises, over_n, first_rise;
  logic [N-1:0] acks;

  // Called at a negedge; drives cycle c's inputs and samples the outputs
  // produced by the previous edge, then advances one clock.
  task automatic run_case(input int cycles);
    logic prev_led;
    busy_n = 0; rises = 0; over_n = 0; first_rise = -1; acks = '0;
    prev_led = led;
    for (int c = 0; c < cycles; c++) begin
      req     = (c < 16) ? rq_s[c] : '0;
      enable  = (c < 16) ? en_s[c] : en_s[15];
      n_reset = (c < 16) ? rs_s[c] : 1'b0;
      if (busy) busy_n++;
      if (led && !prev_led) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev_led = led;
      acks = acks | ack;
      for (int k = 0; k < N; k++) if (overrun[k]) over_n++;
      @(negedge clk);
    end
  endtask

  task automatic expect_case(input string name, input int e_busy, input int e_rises,
                             input logic [N-1:0] e_acks, input int e_over, input int e_first);
    chk({name, "_busy_clks"}, 32'(busy_n), 32'(e_busy));
    chk({name, "_blinks"}, 32'(rises), 32'(e_rises));
    chk({name, "_acks"}, 32'(acks), 32'(e_acks));
    chk({name, "_overruns"}, 32'(over_n), 32'(e_over));
    chk({name, "_first_rise"}, 32'(first_rise), 32'(e_first));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_reset = 1'b1;
    req = 4'hF;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);

    // Release with req dropped: nothing latched during reset may start.
    clear_stim(1'b1);
    run_case(20);
    expect_case("post_reset", 0, 0, 4'b0000, 0, -1);

    // Single req[2] pulse: 3 blinks, busy 3*4 + 2*3 + 10 = 28.
    clear_stim(1'b1);
    rq_s[0] = 4'b0100;
    run_case(40);
    expect_case("code2", 28, 3, 4'b0100, 0, 2);

    // req[0] and req[3] together: code 0 (14 busy), idle, code 3 (35 busy).
    clear_stim(1'b1);
    rq_s[0] = 4'b1001;
    run_case(60);
    expect_case("prio", 49, 5, 4'b1001, 0, 2);

    // req[1] pulsed twice while code 0 runs: one overrun, one 2-blink code.
    clear_stim(1'b1);
    rq_s[0] = 4'b0001;
    rq_s[3] = 4'b0010;
    rq_s[6] = 4'b0010;
    run_case(45);
    expect_case("overrun", 35, 3, 4'b0011, 1, 2);

    // enable low holds pending[1]; raising it starts the code next clock;
    // dropping it during the first blink must not abort the code.
    clear_stim(1'b0);
    rq_s[0] = 4'b0010;
    run_case(30);
    expect_case("gated", 0, 0, 4'b0000, 0, -1);
    clear_stim(1'b0);
    en_s[0] = 1'b1; en_s[1] = 1'b1; en_s[2] = 1'b1;
    run_case(30);
    expect_case("enable_drop", 21, 2, 4'b0010, 0, 1);

    // Reset during the second on-period of code 2, with req[1] pending.
    clear_stim(1'b1);
    rq_s[0] = 4'b0100;
    rq_s[5] = 4'b0010;
    rs_s[10] = 1'b1;
    rs_s[11] = 1'b1;
    run_case(40);
    expect_case("abort", 9, 2, 4'b0000, 0, 2);

    // req[0] held for 16 clocks: two back-to-back codes with one idle clock.
    clear_stim(1'b1);
    for (int i = 0; i < 16; i++) rq_s[i] = 4'b0001;
    run_case(40);
    expect_case("held", 28, 2, 4'b0001, 15, 2);

    chk("final_idle", 32'(busy), 32'd0);
    chk("final_grant", 32'(grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
